ifft8_stream: RTL and testbench
===============================

IFFT8_STREAM -- requirements
Module: ifft8_stream

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the width of each real/imag sample, two's complement.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  the input sample is valid.
REQ-005 SHALL have port in_ready  output  1  the block accepts an input sample this cycle.
REQ-006 SHALL have ports in_real and in_imag  input  DW each  the frequency-domain sample X[k]; k is implied by acceptance order 0..7.
REQ-007 SHALL have port out_valid  output  1  the output sample is valid.
REQ-008 SHALL have port out_ready  input  1  the consumer accepts the output sample.
REQ-009 SHALL have ports out_real and out_imag  output  DW each  the time-domain sample x[n].
REQ-010 SHALL have port out_index  output  3  n of the current output sample.
REQ-011 SHALL have port out_last  output  1  high with out_index==7.

Function
REQ-012 SHALL compute x[n] = (1/8)·Σk X[k]·e^(+j2πkn/8) for one 8-sample frame, i.e. the inverse of the team's 8-point radix-2 DIT FFT.
REQ-013 SHALL transfer an input sample on a cycle where in_valid&&in_ready, and an output sample on a cycle where out_valid&&out_ready.
REQ-014 SHALL implement FSM states LOAD, COMPUTE and UNLOAD; reset enters LOAD.
REQ-015 LOAD: in_ready=1; the k-th accepted sample is written to buffer address bitrev3(k); the 8th acceptance moves the FSM to COMPUTE with stage counter 0.
REQ-016 COMPUTE: in_ready=0, out_valid=0; exactly one butterfly stage per cycle over all 4 pairs; after stage 2 the FSM moves to UNLOAD; duration is exactly 3 cycles.
REQ-017 Stage s (0..2) SHALL use span 2^s: for pair (a, b=a+span) with twiddle W=e^(+j2π·m/2^(s+1)), where m=a mod span, compute t=W·x[b], x[a]'=(x[a]+t)>>>1 and x[b]'=(x[a]−t)>>>1.
REQ-018 Butterfly add/subtract SHALL be done at DW+1 bits, then arithmetic right shift by 1 (truncation toward −inf) to DW bits; the three shifts provide the 1/8 scale.
REQ-019 Twiddle W=1 SHALL pass t unchanged; W=+j SHALL give t=(−im, re) exactly; W=(±1+j)/√2 SHALL give re'=(C·(±re−im)+2^14)>>>15 and im'=(C·(re±im)+2^14)>>>15, with C=23170, the sums formed at DW+1 bits and the result truncated to DW bits.
REQ-020 UNLOAD: in_ready=0; out_valid=1; outputs are presented in natural order n=0..7, with out_index=n and out_last=(n==7).
REQ-021 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-022 The transfer of n=7 SHALL return the FSM to LOAD, with in_ready=1 on the next cycle; frames do not overlap.
REQ-023 Latency: first out_valid SHALL occur exactly 4 cycles after the cycle that accepts input sample 7.
REQ-024 in_real and in_imag SHALL be ignored whenever in_ready=0.

Reset
REQ-025 rst=1 SHALL force the FSM to LOAD, clear the input count, stage and output counters, and set in_ready=1, out_valid=0, out_last=0, out_index=0, out_real=0 and out_imag=0 on the next edge.
REQ-026 rst asserted mid-LOAD, mid-COMPUTE or mid-UNLOAD SHALL abandon the partial frame; no stale output is emitted afterwards.
REQ-027 Buffer contents need not be cleared by reset.

Structure
REQ-028 Package ifft8_pkg SHALL hold the following, shared with the FFT block: N=8, LOG2N=3, the default DW, the constant C=23170 (Q1.15 of 1/√2), the FSM state enum, and the bitrev3 function.
REQ-029 One sub-module, ifft_bfly, SHALL implement the combinational twiddle multiply plus scaled butterfly of REQ-017 to REQ-019, with a 2-bit twiddle select; ifft8_stream SHALL instantiate 4 of these per stage cycle.

Verification
REQ-030 Input X[0]=(8000,0), others 0 -> all 8 outputs are (1000,0), out_last only at n=7.
REQ-031 Input all eight X[k]=(8000,0) -> x[0]=(8000,0) and x[1..7]=(0,0).
REQ-032 Input X[1]=(8000,0), others 0 -> x[n]=1000·e^(+j2πn/8) within ±1 LSB (x[1]≈(707,707), x[2]=(0,1000)); first out_valid exactly 4 cycles after the 8th acceptance.
REQ-033 out_ready toggled randomly during UNLOAD -> outputs stable while stalled, none lost or duplicated, in_ready=0 until n=7 transfers.
REQ-034 rst pulsed during COMPUTE and again at n=3 of UNLOAD -> next cycle in_ready=1 and out_valid=0, and a following clean frame yields the REQ-030 result.

Source files
------------

// File: rtl/ifft8_pkg.sv
// Shared constants, types and helpers for the 8-point FFT/IFFT stream blocks.
package ifft8_pkg;

  localparam int unsigned N          = 8;
  localparam int unsigned LOG2N      = 3;
  localparam int unsigned DW_DEFAULT = 16;
  localparam int          C_RSQ2     = 23170;
  localparam int          RND_Q15    = 16384;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_UNLOAD
  } state_e;

  // Twiddle select: 1, +j, (+1+j)/sqrt2, (-1+j)/sqrt2
  typedef enum logic [1:0] {
    TW_ONE,
    TW_J,
    TW_P45,
    TW_P135
  } tw_e;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Lower index of butterfly pair p in stage s (span 2^s)
  function automatic logic [LOG2N-1:0] pair_a(input logic [1:0] s, input logic [1:0] p);
    logic [LOG2N-1:0] a;
    case (s)
      2'd0:    a = {p, 1'b0};
      2'd1:    a = {p[1], 1'b0, p[0]};
      default: a = {1'b0, p};
    endcase
    return a;
  endfunction

  function automatic tw_e tw_sel(input logic [1:0] s, input logic [1:0] p);
    tw_e sel;
    sel = TW_ONE;
    case (s)
      2'd1: sel = p[0] ? TW_J : TW_ONE;
      2'd2: begin
        case (p)
          2'd1:    sel = TW_P45;
          2'd2:    sel = TW_J;
          2'd3:    sel = TW_P135;
          default: sel = TW_ONE;
        endcase
      end
      default: sel = TW_ONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational twiddle multiply plus halving radix-2 butterfly.
module ifft_bfly
  import ifft8_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  tw_e           sel,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  output logic [DW-1:0] ya_re_c,
  output logic [DW-1:0] ya_im_c,
  output logic [DW-1:0] yb_re_c,
  output logic [DW-1:0] yb_im_c
);

  localparam int unsigned PW = DW + 18;

  logic signed [DW:0]   b_re_x, b_im_x, a_re_x, a_im_x, t_re_x, t_im_x;
  logic signed [DW:0]   sum_re, sum_im, s_re, s_im, d_re, d_im;
  logic signed [PW-1:0] prod_re, prod_im;
  logic        [DW-1:0] t_re, t_im;

  always_comb begin
    b_re_x = {b_re[DW-1], b_re};
    b_im_x = {b_im[DW-1], b_im};
    a_re_x = {a_re[DW-1], a_re};
    a_im_x = {a_im[DW-1], a_im};

    // Diagonal twiddles share one rounded Q1.15 multiply per component
    sum_re  = (sel == TW_P45) ? (b_re_x - b_im_x) : (-b_re_x - b_im_x);
    sum_im  = (sel == TW_P45) ? (b_re_x + b_im_x) : (b_re_x - b_im_x);
    prod_re = PW'(sum_re) * PW'(C_RSQ2) + PW'(RND_Q15);
    prod_im = PW'(sum_im) * PW'(C_RSQ2) + PW'(RND_Q15);

    unique case (sel)
      TW_ONE: begin
        t_re = b_re;
        t_im = b_im;
      end
      TW_J: begin
        t_re = DW'(-b_im_x);
        t_im = b_re;
      end
      default: begin
        t_re = DW'(prod_re >>> 15);
        t_im = DW'(prod_im >>> 15);
      end
    endcase

    t_re_x = {t_re[DW-1], t_re};
    t_im_x = {t_im[DW-1], t_im};
    s_re   = a_re_x + t_re_x;
    s_im   = a_im_x + t_im_x;
    d_re   = a_re_x - t_re_x;
    d_im   = a_im_x - t_im_x;

    ya_re_c = DW'(s_re >>> 1);
    ya_im_c = DW'(s_im >>> 1);
    yb_re_c = DW'(d_re >>> 1);
    yb_im_c = DW'(d_im >>> 1);
  end

endmodule

// File: rtl/ifft8_stream.sv
// Streaming 8-point inverse FFT: load 8 samples, 3 in-place butterfly stages, unload in natural order.
module ifft8_stream
  import ifft8_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [2:0]    out_index,
  output logic          out_last
);

  state_e               state_q, state_d;
  logic [LOG2N-1:0]     cnt_q, cnt_d;
  logic [1:0]           stg_q, stg_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [2:0]           out_index_q, out_index_d;
  logic [DW-1:0]        out_real_q, out_real_d;
  logic [DW-1:0]        out_imag_q, out_imag_d;
  logic [DW-1:0]        buf_re_q [N];
  logic [DW-1:0]        buf_im_q [N];
  logic [DW-1:0]        buf_re_d [N];
  logic [DW-1:0]        buf_im_d [N];

  logic [LOG2N-1:0]     pa [4];
  logic [LOG2N-1:0]     pb [4];
  tw_e                  psel [4];
  logic [DW-1:0]        bf_ar [4], bf_ai [4], bf_br [4], bf_bi [4];
  logic [DW-1:0]        ya_re [4], ya_im [4], yb_re [4], yb_im [4];

  // Pair addressing and operand fetch for the current stage
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      pa[p]    = pair_a(stg_q, 2'(p));
      pb[p]    = pa[p] + (3'd1 << stg_q);
      psel[p]  = tw_sel(stg_q, 2'(p));
      bf_ar[p] = buf_re_q[pa[p]];
      bf_ai[p] = buf_im_q[pa[p]];
      bf_br[p] = buf_re_q[pb[p]];
      bf_bi[p] = buf_im_q[pb[p]];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_bfly
    ifft_bfly #(.DW(DW)) u_bfly (
      .sel     (psel[g]),
      .a_re    (bf_ar[g]),
      .a_im    (bf_ai[g]),
      .b_re    (bf_br[g]),
      .b_im    (bf_bi[g]),
      .ya_re_c (ya_re[g]),
      .ya_im_c (ya_im[g]),
      .yb_re_c (yb_re[g]),
      .yb_im_c (yb_im[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stg_d       = stg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;

    unique case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready_q) begin
          buf_re_d[bitrev3(cnt_q)] = in_real;
          buf_im_d[bitrev3(cnt_q)] = in_imag;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d    = ST_COMPUTE;
            stg_d      = 2'd0;
            in_ready_d = 1'b0;
          end
        end
      end
      ST_COMPUTE: begin
        for (int p = 0; p < 4; p++) begin
          buf_re_d[pa[p]] = ya_re[p];
          buf_im_d[pa[p]] = ya_im[p];
          buf_re_d[pb[p]] = yb_re[p];
          buf_im_d[pb[p]] = yb_im[p];
        end
        stg_d = stg_q + 2'd1;
        // Last stage result for x[0] goes straight to the output register
        if (stg_q == 2'd2) begin
          state_d     = ST_UNLOAD;
          stg_d       = 2'd0;
          out_valid_d = 1'b1;
          out_index_d = 3'd0;
          out_last_d  = 1'b0;
          out_real_d  = ya_re[0];
          out_imag_d  = ya_im[0];
        end
      end
      ST_UNLOAD: begin
        if (out_valid_q && out_ready) begin
          if (out_index_q == 3'd7) begin
            state_d     = ST_LOAD;
            cnt_d       = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_index_d = 3'd0;
            out_real_d  = '0;
            out_imag_d  = '0;
          end else begin
            out_index_d = out_index_q + 3'd1;
            out_last_d  = (out_index_q == 3'd6);
            out_real_d  = buf_re_q[out_index_q + 3'd1];
            out_imag_d  = buf_im_q[out_index_q + 3'd1];
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      stg_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stg_q       <= stg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  // Sample buffer is not reset; the counters make stale contents unreachable
  always_ff @(posedge clk) begin
    buf_re_q <= buf_re_d;
    buf_im_q <= buf_im_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_index_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;

endmodule

// File: tb/tb_ifft8_stream.sv
// Directed self-checking bench for ifft8_stream.
module tb_ifft8_stream;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_real, in_imag, out_real, out_imag;
  logic [2:0]    out_index;

  int total = 0;
  int bad   = 0;
  int fr_re [8], fr_im [8], exp_re [8], exp_im [8];

  always #5 clk = ~clk;

  ifft8_stream #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_index (out_index),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Feed fr_* samples 0..nsamp-1; optionally leave junk driven with in_valid high
  task automatic send(input int nsamp, input bit junk);
    for (int k = 0; k < nsamp; k++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        chk("send_in_ready", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      in_valid = 1'b1;
      in_real  = DW'(fr_re[k]);
      in_imag  = DW'(fr_im[k]);
      @(posedge clk);
    end
    #1;
    if (junk) begin
      in_real = 16'h5A5A;
      in_imag = 16'hA5A5;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Called right after the 8th acceptance edge
  task automatic wait_first();
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("in_ready_compute", in_ready, 0);
      if (out_valid) break;
    end
    in_valid = 1'b0;
    chk("latency", n, 4);
  endtask

  task automatic recv(input int nout, input bit rnd);
    logic [DW-1:0] hr, hi;
    logic [2:0]    hx;
    logic          hl;
    bit            held;
    held = 1'b0;
    for (int n = 0; n < nout; n++) begin
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      while (!done && guard < 100) begin
        @(negedge clk);
        guard++;
        if (held) begin
          chk($sformatf("hold_re%0d", n), out_real, hr);
          chk($sformatf("hold_im%0d", n), out_imag, hi);
          chk($sformatf("hold_idx%0d", n), out_index, hx);
          chk($sformatf("hold_last%0d", n), out_last, hl);
        end
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) begin
          chk($sformatf("idx%0d", n), out_index, n);
          chk($sformatf("last%0d", n), out_last, (n == 7) ? 1 : 0);
          chk($sformatf("re%0d", n), $signed(out_real), exp_re[n]);
          chk($sformatf("im%0d", n), $signed(out_imag), exp_im[n]);
          chk($sformatf("in_ready_unload%0d", n), in_ready, 0);
          done = 1'b1;
          held = 1'b0;
        end else if (out_valid) begin
          held = 1'b1;
          hr = out_real;
          hi = out_imag;
          hx = out_index;
          hl = out_last;
        end
      end
      if (!done) begin
        chk($sformatf("recv_valid%0d", n), out_valid, 1);
        out_ready = 1'b0;
        return;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (nout == 8) begin
      chk("in_ready_after", in_ready, 1);
      chk("out_valid_after", out_valid, 0);
    end
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_index"}, out_index, 0);
  endtask

  task automatic set_impulse();
    for (int i = 0; i < 8; i++) begin
      fr_re[i]  = 0;
      fr_im[i]  = 0;
      exp_re[i] = 1000;
      exp_im[i] = 0;
    end
    fr_re[0] = 8000;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_real", out_real, 0);
    chk("rst_out_imag", out_imag, 0);
    rst = 1'b0;

    // Impulse at k=0 -> flat 1000, with junk on inputs during compute
    set_impulse();
    send(8, 1'b1);
    wait_first();
    recv(8, 1'b0);

    // All-8000 input -> single 8000 at n=0, random output stalls
    for (int i = 0; i < 8; i++) begin
      fr_re[i]  = 8000;
      fr_im[i]  = 0;
      exp_re[i] = 0;
      exp_im[i] = 0;
    end
    exp_re[0] = 8000;
    send(8, 1'b1);
    wait_first();
    recv(8, 1'b1);

    // Single tone at k=1 -> 1000*e^(+j2pi n/8)
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = 0;
      fr_im[i] = 0;
    end
    fr_re[1] = 8000;
    exp_re   = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    exp_im   = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    send(8, 1'b1);
    wait_first();
    recv(8, 1'b0);

    // Reset mid-LOAD, then a clean impulse frame
    for (int i = 0; i < 8; i++) fr_re[i] = 3000;
    send(3, 1'b0);
    @(negedge clk);
    pulse_rst("rst_load");
    set_impulse();
    send(8, 1'b0);
    wait_first();
    recv(8, 1'b0);

    // Reset mid-COMPUTE
    send(8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    pulse_rst("rst_compute");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale_c%0d", i), out_valid, 0);
    end

    // Reset at n=3 of UNLOAD
    send(8, 1'b0);
    wait_first();
    recv(3, 1'b0);
    chk("idx_before_rst", out_index, 3);
    pulse_rst("rst_unload");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no_stale_u%0d", i), out_valid, 0);
    end

    // Clean frame after resets
    send(8, 1'b1);
    wait_first();
    recv(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
